// File: rtl/oam_dma_ctrl_if.sv
// CPU and shared-memory bus bundle for the OAM DMA controller.
// master: the DMA controller view (drives memory bus and CPU return path).
// slave:  the environment view (CPU master and shared memory).
interface oam_dma_ctrl_if #(
  parameter int unsigned REG_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [REG_WIDTH-1:0]  cpu_wdata;
  logic                  cpu_we;
  logic [REG_WIDTH-1:0]  cpu_rdata;
  logic                  cpu_rdy;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [REG_WIDTH-1:0]  mem_wdata;
  logic                  mem_we;
  logic [REG_WIDTH-1:0]  mem_rdata;

  modport master (
    input  cpu_addr, cpu_wdata, cpu_we, mem_rdata,
    output cpu_rdata, cpu_rdy, mem_addr, mem_wdata, mem_we
  );

  modport slave (
    output cpu_addr, cpu_wdata, cpu_we, mem_rdata,
    input  cpu_rdata, cpu_rdy, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/oam_dma_ctrl.sv
// OAM DMA controller: a CPU write to DMA_REG_ADDR copies one 256-byte page
// to the OAM data port, stalling the CPU for the whole transfer.
// Optional macro OAM_DMA_ALIGN_EN adds an ALIGN state that waits for the
// read/write cycle parity before the copy starts.
module oam_dma_ctrl #(
  parameter int unsigned           REG_WIDTH     = 8,
  parameter int unsigned           ADDR_WIDTH    = 16,
  parameter logic [ADDR_WIDTH-1:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [ADDR_WIDTH-1:0] OAM_DATA_ADDR = 16'h2004,
  parameter int unsigned           DMA_LEN       = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  oam_dma_ctrl_if.master       bus,
  output logic                 dma_busy,
  output logic                 dma_done
);

`ifdef OAM_DMA_ALIGN_EN
  typedef enum logic [1:0] {StIdle, StAlign, StRead, StWrite} state_e;
`else
  typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;
`endif

  state_e               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [7:0]           page_q, page_d;
  logic [REG_WIDTH-1:0] data_q, data_d;
  logic                 done_q, done_d;

`ifdef OAM_DMA_ALIGN_EN
  logic parity_q;
  // Set when the trigger landed on an odd cycle: ALIGN needs one extra cycle.
  logic align_q, align_d;

  // Free-running cycle parity and ALIGN extra-cycle flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_q <= 1'b0;
      align_q  <= 1'b0;
    end else begin
      parity_q <= ~parity_q;
      align_q  <= align_d;
    end
  end
`endif

  // Transfer state, counters and data latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      page_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      page_q  <= page_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  // Next-state and bus muxing; reset cycles look like IDLE pass-through.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    page_d  = page_q;
    data_d  = data_q;
    done_d  = 1'b0;
`ifdef OAM_DMA_ALIGN_EN
    align_d = align_q;
`endif
    bus.mem_addr  = bus.cpu_addr;
    bus.mem_wdata = bus.cpu_wdata;
    bus.mem_we    = bus.cpu_we;
    bus.cpu_rdata = bus.mem_rdata;
    bus.cpu_rdy   = 1'b1;
    dma_busy      = 1'b0;

    if (!reset) begin
      if (state_q != StIdle) begin
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_we    = 1'b0;
        bus.cpu_rdata = '0;
        bus.cpu_rdy   = 1'b0;
        dma_busy      = 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (bus.cpu_we && (bus.cpu_addr == DMA_REG_ADDR)) begin
            page_d = bus.cpu_wdata[7:0];
            cnt_d  = '0;
`ifdef OAM_DMA_ALIGN_EN
            align_d = parity_q;
            state_d = StAlign;
`else
            state_d = StRead;
`endif
          end
        end
`ifdef OAM_DMA_ALIGN_EN
        StAlign: begin
          if (align_q) begin
            align_d = 1'b0;
          end else begin
            state_d = StRead;
          end
        end
`endif
        StRead: begin
          bus.mem_addr = ADDR_WIDTH'({page_q, cnt_q});
          data_d       = bus.mem_rdata;
          state_d      = StWrite;
        end
        StWrite: begin
          bus.mem_addr  = OAM_DATA_ADDR;
          bus.mem_wdata = data_q;
          bus.mem_we    = 1'b1;
          // 8-bit wrap: the last byte of the page ends the transfer, no page carry.
          cnt_d         = cnt_q + 8'd1;
          if (cnt_q == 8'(DMA_LEN - 1)) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            state_d = StRead;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign dma_done = done_q;

endmodule
